// File: rtl/pad_attr_pkg.sv
// Shared types and the per-pad-type WARL mask for the pad attribute controller.
package pad_attr_pkg;

    localparam int unsigned MaxAttrDw = 64;

    typedef enum logic [2:0] {
        PAD_FULL    = 3'd0,
        PAD_GENERIC = 3'd1,
        PAD_XILINX  = 3'd2
    } pad_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_GAP   = 2'd2,
        ST_FIN   = 2'd3
    } sweep_state_e;

    // Bits a given pad implementation actually stores; reserved types store nothing.
    function automatic logic [MaxAttrDw-1:0] warl_mask(input logic [2:0] pad_type,
                                                       input int unsigned attr_dw);
        logic [MaxAttrDw-1:0] ones;
        ones = {MaxAttrDw{1'b1}} >> (MaxAttrDw - attr_dw);
        case (pad_type)
            PAD_FULL:    return ones;
            PAD_GENERIC: return ones & MaxAttrDw'(64'h1);
            PAD_XILINX:  return ones & MaxAttrDw'(64'h1F);
            default:     return '0;
        endcase
    endfunction

endpackage

// File: rtl/pad_attr_sweep_fsm.sv
// Commit sweep sequencer: walks pads in order, spacing changed pads by ApplyGap cycles.
module pad_attr_sweep_fsm
    import pad_attr_pkg::*;
#(
    parameter  int unsigned NDioPads = 24,
    parameter  int unsigned ApplyGap = 2,
    localparam int unsigned IdxW     = (NDioPads > 1) ? $clog2(NDioPads) : 1,
    localparam int unsigned GapW     = $clog2(ApplyGap) + 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_commit,
    input  logic            i_diff,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_apply_en_c,
    output logic [IdxW-1:0] o_apply_idx
);

    localparam logic [IdxW:0]   LastIdx = (IdxW+1)'(NDioPads - 1);
    localparam logic [GapW-1:0] GapInit = GapW'(ApplyGap - 1);

    sweep_state_e    r_state, w_state_nxt;
    logic [IdxW:0]   r_idx, w_idx_nxt;
    logic [GapW-1:0] r_gap, w_gap_nxt;
    logic            r_pend, w_pend_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_done, w_done_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_gap   <= '0;
            r_pend  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_gap   <= w_gap_nxt;
            r_pend  <= w_pend_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_gap_nxt   = r_gap;
        w_pend_nxt  = r_pend;
        case (r_state)
            ST_IDLE: begin
                if (i_commit) begin
                    w_state_nxt = ST_CHECK;
                    w_idx_nxt   = '0;
                end
            end
            ST_CHECK: begin
                w_pend_nxt = r_pend | i_commit;
                if (i_diff && (GapInit != '0)) begin
                    w_gap_nxt   = GapInit;
                    w_state_nxt = ST_GAP;
                end else if (r_idx == LastIdx) begin
                    w_state_nxt = ST_FIN;
                end else begin
                    w_idx_nxt = r_idx + (IdxW+1)'(1);
                end
            end
            ST_GAP: begin
                w_pend_nxt = r_pend | i_commit;
                w_gap_nxt  = r_gap - GapW'(1);
                if (r_gap == GapW'(1)) begin
                    if (r_idx == LastIdx) begin
                        w_state_nxt = ST_FIN;
                    end else begin
                        w_idx_nxt   = r_idx + (IdxW+1)'(1);
                        w_state_nxt = ST_CHECK;
                    end
                end
            end
            ST_FIN: begin
                // A commit arriving in the final cycle also chains straight into a new sweep.
                if (r_pend || i_commit) begin
                    w_pend_nxt  = 1'b0;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_apply_en_c = (r_state == ST_CHECK) && i_diff;
        w_done_nxt   = (w_state_nxt == ST_FIN);
        w_busy_nxt   = (w_state_nxt == ST_CHECK) || (w_state_nxt == ST_GAP) ||
                       ((w_state_nxt == ST_FIN) && w_pend_nxt);
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_apply_idx = r_idx[IdxW-1:0];

endmodule

// File: rtl/pad_attr_ctrl.sv
// Staged/active pad attribute storage with WARL masking and a gap-paced commit sweep.
module pad_attr_ctrl
    import pad_attr_pkg::*;
#(
    parameter  int unsigned NDioPads = 24,
    parameter  int unsigned AttrDw   = 13,
    parameter  logic [2:0]  PadType  = 3'b001,
    parameter  int unsigned ApplyGap = 2,
    localparam int unsigned IdxW     = (NDioPads > 1) ? $clog2(NDioPads) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_req_i,
    output logic                       wr_gnt_o,
    input  logic [IdxW-1:0]            wr_idx_i,
    input  logic [AttrDw-1:0]          wr_data_i,
    input  logic [IdxW-1:0]            rd_idx_i,
    output logic [AttrDw-1:0]          rd_data_o,
    input  logic                       commit_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [NDioPads*AttrDw-1:0] attr_o,
    output logic [AttrDw-1:0]          warl_mask_o
);

    localparam logic [AttrDw-1:0] WarlMask = AttrDw'(warl_mask(PadType, AttrDw));
    localparam logic [IdxW:0]     NPads    = (IdxW+1)'(NDioPads);

    logic [AttrDw-1:0] r_staged [NDioPads];
    logic [AttrDw-1:0] r_active [NDioPads];

    logic            w_busy;
    logic            w_done;
    logic            w_apply_en;
    logic [IdxW-1:0] w_apply_idx;
    logic            w_diff;
    logic            w_wr_in_range;
    logic            w_rd_in_range;

    assign w_wr_in_range = ({1'b0, wr_idx_i} < NPads);
    assign w_rd_in_range = ({1'b0, rd_idx_i} < NPads);
    assign w_diff        = (r_staged[w_apply_idx] != r_active[w_apply_idx]);

    assign wr_gnt_o    = wr_req_i & ~w_busy;
    assign rd_data_o   = w_rd_in_range ? r_staged[rd_idx_i] : '0;
    assign warl_mask_o = WarlMask;
    assign busy_o      = w_busy;
    assign done_o      = w_done;

    // Out-of-range writes are accepted so the requester never stalls on a bad index.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < int'(NDioPads); k++) r_staged[k] <= '0;
        end else if (wr_gnt_o && w_wr_in_range) begin
            r_staged[wr_idx_i] <= wr_data_i & WarlMask;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < int'(NDioPads); k++) r_active[k] <= '0;
        end else if (w_apply_en) begin
            r_active[w_apply_idx] <= r_staged[w_apply_idx];
        end
    end

    for (genvar k = 0; k < int'(NDioPads); k++) begin : g_attr
        assign attr_o[k*AttrDw +: AttrDw] = r_active[k];
    end

    pad_attr_sweep_fsm #(
        .NDioPads (NDioPads),
        .ApplyGap (ApplyGap)
    ) u_sweep (
        .i_clk        (clk_i),
        .i_rst        (rst_i),
        .i_commit     (commit_i),
        .i_diff       (w_diff),
        .o_busy       (w_busy),
        .o_done       (w_done),
        .o_apply_en_c (w_apply_en),
        .o_apply_idx  (w_apply_idx)
    );

endmodule

// File: tb/tb_pad_attr_ctrl.sv
// Directed bench for pad_attr_ctrl: full-featured instance for sweeps, generic instance for masking.
module tb_pad_attr_ctrl;

    localparam int unsigned NP = 24;
    localparam int unsigned DW = 13;
    localparam int unsigned IW = 5;
    localparam int unsigned CW = 320;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_req = 1'b0;
    logic [IW-1:0] wr_idx = '0;
    logic [DW-1:0] wr_data = '0;
    logic [IW-1:0] rd_idx = '0;
    logic          commit = 1'b0;
    logic          wr_gnt;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic [NP*DW-1:0] attr;
    logic [DW-1:0] mask;

    logic          g_wr_req = 1'b0;
    logic [IW-1:0] g_wr_idx = '0;
    logic [DW-1:0] g_wr_data = '0;
    logic [IW-1:0] g_rd_idx = '0;
    logic          g_wr_gnt;
    logic [DW-1:0] g_rd_data;
    logic          g_busy;
    logic          g_done;
    logic [NP*DW-1:0] g_attr;
    logic [DW-1:0] g_mask;

    int n_checks = 0;
    int n_fail   = 0;

    logic [CW-1:0] exp_attr = '0;
    logic [DW-1:0] exp_stg [NP];

    always #5 clk = ~clk;

    pad_attr_ctrl #(.NDioPads(NP), .AttrDw(DW), .PadType(3'd0), .ApplyGap(2)) u_dut (
        .clk_i(clk), .rst_i(rst), .wr_req_i(wr_req), .wr_gnt_o(wr_gnt),
        .wr_idx_i(wr_idx), .wr_data_i(wr_data), .rd_idx_i(rd_idx), .rd_data_o(rd_data),
        .commit_i(commit), .busy_o(busy), .done_o(done), .attr_o(attr), .warl_mask_o(mask)
    );

    pad_attr_ctrl #(.NDioPads(NP), .AttrDw(DW), .PadType(3'd1), .ApplyGap(2)) u_dut_gen (
        .clk_i(clk), .rst_i(rst), .wr_req_i(g_wr_req), .wr_gnt_o(g_wr_gnt),
        .wr_idx_i(g_wr_idx), .wr_data_i(g_wr_data), .rd_idx_i(g_rd_idx), .rd_data_o(g_rd_data),
        .commit_i(1'b0), .busy_o(g_busy), .done_o(g_done), .attr_o(g_attr), .warl_mask_o(g_mask)
    );

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input logic [DW-1:0] data);
        wr_req  = 1'b1;
        wr_idx  = IW'(idx);
        wr_data = data;
        tick();
        wr_req  = 1'b0;
        if (idx < int'(NP)) exp_stg[idx] = data;
    endtask

    initial begin
        int p0, p5, bcnt, dcnt, dcyc, d1, d2, gc, bad, low, high;
        logic [CW-1:0] other, pmask;

        for (int k = 0; k < int'(NP); k++) exp_stg[k] = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // reset state and masks
        chk("rst_attr", CW'(attr), '0);
        chk("rst_busy", CW'(busy), '0);
        chk("rst_done", CW'(done), '0);
        chk("mask_full", CW'(mask), CW'(13'h1FFF));
        chk("mask_gen", CW'(g_mask), CW'(13'h0001));

        // generic pad keeps only the invert bit
        g_wr_req = 1'b1; g_wr_idx = 5'd3; g_wr_data = 13'h1FFF;
        #1;
        chk("gen_gnt", CW'(g_wr_gnt), CW'(1'b1));
        tick();
        g_wr_req = 1'b0; g_rd_idx = 5'd3;
        #1;
        chk("gen_rd3", CW'(g_rd_data), CW'(13'h0001));

        // sweep timing with pads 0 and 5 changed
        wr(0, 13'h0A5);
        wr(5, 13'h0A5);
        exp_attr[0 +: DW]    = 13'h0A5;
        exp_attr[5*DW +: DW] = 13'h0A5;
        pmask = '0;
        pmask[0 +: DW]    = '1;
        pmask[5*DW +: DW] = '1;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        p0 = -1; p5 = -1; bcnt = 0; dcnt = 0; dcyc = -1; other = '0;
        for (int c = 0; c < 40; c++) begin
            if (attr[0 +: DW] != '0 && p0 < 0) p0 = c;
            if (attr[5*DW +: DW] != '0 && p5 < 0) p5 = c;
            if (busy) bcnt++;
            if (done) begin dcnt++; dcyc = c; end
            other |= CW'(attr) & ~pmask;
            tick();
        end
        chk("sw_pad0_cyc", CW'(p0), CW'(1));
        chk("sw_pad5_cyc", CW'(p5), CW'(7));
        chk("sw_busy_cycles", CW'(bcnt), CW'(26));
        chk("sw_done_count", CW'(dcnt), CW'(1));
        chk("sw_done_cyc", CW'(dcyc), CW'(26));
        chk("sw_other_bits", other, '0);
        chk("sw_attr", CW'(attr), exp_attr);

        // write stall during an all-unchanged sweep
        commit = 1'b1;
        tick();
        commit = 1'b0;
        wr_req = 1'b1; wr_idx = 5'd2; wr_data = 13'h0123;
        gc = -1; bad = 0; dcyc = -1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (wr_gnt && busy) bad++;
            if (done) dcyc = c;
            if (wr_gnt) begin
                gc = c;
                tick();
                break;
            end
            tick();
        end
        wr_req = 1'b0;
        exp_stg[2] = 13'h0123;
        chk("stall_gnt_busy", CW'(bad), '0);
        chk("stall_first_gnt", CW'(gc), CW'(24));
        chk("stall_done_cyc", CW'(dcyc), CW'(24));
        rd_idx = 5'd2;
        #1;
        chk("stall_rd2", CW'(rd_data), CW'(13'h0123));
        chk("stall_attr", CW'(attr), exp_attr);
        chk("stall_idle", CW'(busy), '0);

        // commits during busy coalesce into one chained sweep
        exp_attr[2*DW +: DW] = 13'h0123;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        dcnt = 0; d1 = -1; d2 = -1; low = 0; high = 0;
        for (int c = 0; c < 70; c++) begin
            if (done) begin
                dcnt++;
                if (d1 < 0) d1 = c; else d2 = c;
            end
            if (c < 50 && !busy) low++;
            if (c >= 50 && busy) high++;
            commit = (c == 3 || c == 5 || c == 8);
            tick();
        end
        commit = 1'b0;
        chk("pend_done_count", CW'(dcnt), CW'(2));
        chk("pend_done1_cyc", CW'(d1), CW'(25));
        chk("pend_done2_cyc", CW'(d2), CW'(50));
        chk("pend_no_idle_gap", CW'(low), '0);
        chk("pend_no_third", CW'(high), '0);
        chk("pend_attr", CW'(attr), exp_attr);

        // out-of-range write is granted and dropped
        wr_req = 1'b1; wr_idx = 5'd30; wr_data = 13'h1FFF;
        #1;
        chk("oor_gnt", CW'(wr_gnt), CW'(1'b1));
        tick();
        wr_req = 1'b0;
        for (int k = 0; k < int'(NP); k++) begin
            rd_idx = IW'(k);
            #1;
            chk($sformatf("oor_stg%0d", k), CW'(rd_data), CW'(exp_stg[k]));
        end
        rd_idx = 5'd30;
        #1;
        chk("oor_rd30", CW'(rd_data), '0);

        // reset while pad 7's gap is in progress
        wr(7, 13'h0055);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        chk("mrst_pad7_applied", CW'(attr[7*DW +: DW]), CW'(13'h0055));
        chk("mrst_busy_before", CW'(busy), CW'(1'b1));
        rst = 1'b1;
        tick();
        chk("mrst_attr", CW'(attr), '0);
        chk("mrst_busy", CW'(busy), '0);
        chk("mrst_done", CW'(done), '0);
        rst = 1'b0;
        dcnt = 0; bcnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) dcnt++;
            if (busy) bcnt++;
            tick();
        end
        chk("mrst_no_done", CW'(dcnt), '0);
        chk("mrst_no_busy", CW'(bcnt), '0);
        rd_idx = 5'd2;
        #1;
        chk("mrst_stg_clear", CW'(rd_data), '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
